// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Character FIFO in front of a UART transmitter. Queued characters are
// popped one at a time, handed to the transmitter with a one-cycle
// tx_write pulse, and the next one is held back until a full frame time
// (start + data + stop + guard bit) has elapsed.
//
// Ports
//   clk            : clock, all state on rising edge
//   rst            : asynchronous active-high reset
//   wr_en/wr_data  : push a character (dropped when full)
//   clear_overflow : clears the sticky overflow flag
//   full/empty     : FIFO occupancy flags (registered)
//   level          : FIFO entry count (registered)
//   overflow       : sticky "a push was dropped" flag
//   busy           : a character is being launched or is in flight
//   tx_write       : one-cycle start pulse to the transmitter
//   tx_data        : character presented to the transmitter
//
// Build option
//   UART_TX_FIFO_OVERFLOW_EN : when defined, dropped pushes set overflow;
//                              otherwise overflow is tied low.
module uart_tx_fifo #(
    parameter int ClockFreqHz     = 10000000,
    parameter int BaudRate        = 9600,
    parameter int DataBitsSizeInt = 8,
    parameter int Depth           = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DataBitsSizeInt-1:0] wr_data,
    input  logic                       clear_overflow,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     level,
    output logic                       overflow,
    output logic                       busy,
    output logic                       tx_write,
    output logic [DataBitsSizeInt-1:0] tx_data
);

    localparam int DW          = DataBitsSizeInt;
    localparam int PtrW        = $clog2(Depth);
    localparam int LvlW        = PtrW + 1;
    localparam int BitCycles   = ClockFreqHz / BaudRate + 1;
    localparam int FrameCycles = (DW + 3) * BitCycles;
    localparam int CntW        = $clog2(FrameCycles);
    localparam logic [CntW-1:0] CntLoad  = CntW'(FrameCycles - 1);
    localparam logic [LvlW-1:0] LvlFull  = LvlW'(Depth);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [DW-1:0]   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, tx_write_q;
    logic [DW-1:0]   tx_data_q;
    logic            push_s, pop_s;

    // FIFO next-state: a pop only happens from IDLE; a push only when not full
    always_comb begin
        pop_s    = (state_q == ST_IDLE) && !empty_q;
        push_s   = wr_en && !full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
        // Flags derive from the next level so they stay consistent with it
        full_d  = (level_d == LvlFull);
        empty_d = (level_d == {LvlW{1'b0}});
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    // Sticky overflow: a drop in the same cycle as a clear wins
    always_comb begin
        overflow_d = (wr_en && full_q) || (overflow_q && !clear_overflow);
    end
`else
    logic unused_clear_s;
    assign unused_clear_s = clear_overflow;

    // Overflow reporting disabled in this build
    always_comb begin
        overflow_d = 1'b0;
    end
`endif

    // Storage array; entries outside the pointer window are never read, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, level and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Launch FSM with registered busy/tx_write/tx_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // tx_write is asserted together with entering LAUNCH
                    tx_write_q <= pop_s;
                    if (pop_s) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        busy_q    <= 1'b1;
                        state_q   <= ST_LAUNCH;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    tx_write_q <= 1'b0;
                    cnt_q      <= CntLoad;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    tx_write_q <= 1'b0;
                    if (cnt_q == {CntW{1'b0}}) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    tx_write_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (10 MHz clock, 1 Mbaud, 8 data bits,
// 4-deep FIFO: frame = 121 cycles, launch spacing = 123 cycles).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clear_overflow;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       tx_write;
    logic [7:0] tx_data;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam logic OvfOn = 1'b1;
`else
    localparam logic OvfOn = 1'b0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         pulse_cnt = 0;
    int         pulse_cyc [16];
    logic [7:0] pulse_dat [16];

    uart_tx_fifo #(
        .ClockFreqHz     (10000000),
        .BaudRate        (1000000),
        .DataBitsSizeInt (8),
        .Depth           (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .clear_overflow (clear_overflow),
        .full           (full),
        .empty          (empty),
        .level          (level),
        .overflow       (overflow),
        .busy           (busy),
        .tx_write       (tx_write),
        .tx_data        (tx_data)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and log any launch pulse seen there
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_write === 1'b1) begin
            if (pulse_cnt < 16) begin
                pulse_cyc[pulse_cnt] = cyc;
                pulse_dat[pulse_cnt] = tx_data;
            end
            pulse_cnt++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL %s_full: got %b exp 0", tag, full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL %s_empty: got %b exp 1", tag, empty); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL %s_level: got %0d exp 0", tag, level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL %s_overflow: got %b exp 0", tag, overflow); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b exp 0", tag, busy); end
        n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL %s_tx_write: got %b exp 0", tag, tx_write); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL %s_tx_data: got %h exp 00", tag, tx_data); end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear_overflow = 1'b0;
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick(); tick();
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_single_push();
        int bad;
        pulse_cnt = 0;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_after_push: got %b exp 0", empty); end
        n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level_after_push: got %0d exp 1", level); end
        n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b exp 0", tx_write); end
        tick();
        n_checks++; if (tx_write !== 1'b1) begin n_fail++; $display("FAIL single_tx_write: got %b exp 1", tx_write); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h exp a5", tx_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d exp 0", level); end
        bad = 0;
        for (int i = 0; i < 121; i++) begin
            tick();
            if (tx_write !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hA5) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_hold: got %0d bad wait cycles exp 0", bad); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_kept: got %h exp a5", tx_data); end
        n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d exp 1", pulse_cnt); end
    endtask

    task automatic test_back_to_back();
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_level_after_pushes: got %0d exp 2", level); end
        repeat (400) tick();
        n_checks++; if (pulse_cnt !== 3) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d exp 3", pulse_cnt); end
        n_checks++; if (pulse_dat[0] !== 8'h11) begin n_fail++; $display("FAIL b2b_data0: got %h exp 11", pulse_dat[0]); end
        n_checks++; if (pulse_dat[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_data1: got %h exp 22", pulse_dat[1]); end
        n_checks++; if (pulse_dat[2] !== 8'h33) begin n_fail++; $display("FAIL b2b_data2: got %h exp 33", pulse_dat[2]); end
        n_checks++; if (pulse_cyc[1] - pulse_cyc[0] !== 123) begin n_fail++; $display("FAIL b2b_gap01: got %0d exp 123", pulse_cyc[1] - pulse_cyc[0]); end
        n_checks++; if (pulse_cyc[2] - pulse_cyc[1] !== 123) begin n_fail++; $display("FAIL b2b_gap12: got %0d exp 123", pulse_cyc[2] - pulse_cyc[1]); end
        n_checks++; if (level !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drained: got level %0d empty %b exp 0/1", level, empty); end
    endtask

    task automatic test_fill_drop();
        pulse_cnt = 0;
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        tick(); tick();
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 3) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full_at3: got %b exp 0", full); end
            end
            if (i == 4) begin
                n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full_at4: got %b exp 1", full); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf_at4: got %b exp 0", overflow); end
            end
        end
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level_after_drop: got %0d exp 4", level); end
        n_checks++; if (overflow !== OvfOn) begin n_fail++; $display("FAIL fill_overflow: got %b exp %b", overflow, OvfOn); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b exp 1", busy); end
    endtask

    task automatic test_clear_overflow();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b exp 0", overflow); end
        wr_en = 1'b1; wr_data = 8'h06; clear_overflow = 1'b1;
        tick();
        wr_en = 1'b0; clear_overflow = 1'b0;
        n_checks++; if (overflow !== OvfOn) begin n_fail++; $display("FAIL clr_with_drop: got %b exp %b", overflow, OvfOn); end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL clr_level: got %0d exp 4", level); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_again: got %b exp 0", overflow); end
    endtask

    task automatic test_drain();
        repeat (900) tick();
        n_checks++; if (pulse_cnt !== 5) begin n_fail++; $display("FAIL drain_pulse_count: got %0d exp 5", pulse_cnt); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (pulse_dat[i] !== 8'(i)) begin n_fail++; $display("FAIL drain_data%0d: got %h exp %h", i, pulse_dat[i], 8'(i)); end
        end
        n_checks++; if (empty !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got empty %b busy %b exp 1/0", empty, busy); end
    endtask

    task automatic test_full_push_pop();
        int found;
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h41 + i);
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b exp 1", full); end
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (busy === 1'b0) found = 1;
            else tick();
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL fpp_idle_timeout: got %0d exp 1", found); end
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL fpp_level: got %0d exp 3", level); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fpp_full_after: got %b exp 0", full); end
        n_checks++; if (tx_write !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL fpp_launch: got %b/%h exp 1/41", tx_write, tx_data); end
        n_checks++; if (overflow !== OvfOn) begin n_fail++; $display("FAIL fpp_overflow: got %b exp %b", overflow, OvfOn); end
    endtask

    task automatic test_reset_mid_frame();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        wr_en = 1'b1; wr_data = 8'h61;
        tick();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_data = 8'h62; tick();
        wr_en = 1'b1; wr_data = 8'h63; tick();
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL rmf_queued: got level %0d busy %b exp 2/1", level, busy); end
        repeat (46) tick();
        #2 rst = 1'b1;
        #1 check_reset_values("rmf_async");
        tick(); tick();
        rst = 1'b0;
        pulse_cnt = 0;
        repeat (300) tick();
        n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL rmf_no_launch: got %0d pulses exp 0", pulse_cnt); end
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rmf_idle: got busy %b empty %b exp 0/1", busy, empty); end
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        tick();
        n_checks++; if (tx_write !== 1'b1 || tx_data !== 8'h77) begin n_fail++; $display("FAIL rmf_new_push: got %b/%h exp 1/77", tx_write, tx_data); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_fill_drop();
        test_clear_overflow();
        test_drain();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter ClockFreqHz, default 10000000, system clock frequency in Hz.
REQ-002 Parameter BaudRate, default 9600, serial bit rate.
REQ-003 Parameter DataBitsSizeInt, default 8, data bits per character (DW).
REQ-004 Parameter Depth, default 16, FIFO entries; power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  push wr_data this cycle.
REQ-008 wr_data  input  DW  character to queue.
REQ-009 clear_overflow  input  1  clears sticky overflow.
REQ-010 full  output  1  FIFO holds Depth entries.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 level  output  $clog2(Depth)+1  current entry count.
REQ-013 overflow  output  1  sticky: a push was dropped.
REQ-014 busy  output  1  a character is being launched or is in flight.
REQ-015 tx_write  output  1  one-cycle start pulse to the downstream transmitter's write input.
REQ-016 tx_data  output  DW  character to the downstream transmitter's write_data input.

Function
REQ-017 Derived constants: BitCycles = ClockFreqHz/BaudRate + 1; FrameCycles = (DW+3)*BitCycles (start + data + stop + one guard bit).
REQ-018 Storage: circular buffer, rd/wr pointers of $clog2(Depth) bits wrapping Depth-1 -> 0; full, empty and level are registered and consistent with each other every cycle.
REQ-019 A push with full=0 stores wr_data at wr pointer, advances it; level +1 unless a pop occurs in the same cycle (then level unchanged).
REQ-020 A push with full=1 is dropped, even if a pop occurs in the same cycle; FIFO contents, pointers and level are unchanged.
REQ-021 States: IDLE, LAUNCH, WAIT; busy = 1 in LAUNCH and WAIT.
REQ-022 IDLE with empty=0: pop the head into the tx_data register, advance rd pointer, go to LAUNCH. IDLE with empty=1: stay.
REQ-023 LAUNCH: tx_write = 1 for exactly this cycle; load the frame counter with FrameCycles-1; go to WAIT.
REQ-024 WAIT: decrement the counter each cycle; on the cycle it reads 0, go to IDLE.
REQ-025 tx_write is 0 in every state other than LAUNCH.
REQ-026 tx_data holds the launched character from LAUNCH through the last WAIT cycle; it changes only on a pop.
REQ-027 Latency: push sampled at edge k into an empty FIFO in IDLE -> tx_write high in the cycle after edge k+1. There is no bypass path.
REQ-028 Back-to-back characters: consecutive tx_write pulses are exactly FrameCycles+2 cycles apart while the FIFO is non-empty.
REQ-029 Pushes are accepted in every state, including during LAUNCH and WAIT.

Reset
REQ-030 While rst=1: state=IDLE; pointers, level, counter = 0; empty=1; full=0; overflow=0; busy=0; tx_write=0; tx_data=0.
REQ-031 Reset mid-frame abandons the frame and discards all queued entries; no tx_write is issued until a new push occurs after reset is released.

Configuration
REQ-032 Macro UART_TX_FIFO_OVERFLOW_EN defined: a dropped push sets overflow; overflow stays set until clear_overflow=1; if clear_overflow and a drop occur in the same cycle, overflow ends at 1.
REQ-033 Macro undefined: overflow is constant 0 and clear_overflow is ignored; drop behaviour in REQ-020 still applies.

Verification (ClockFreqHz=10000000, BaudRate=1000000, DW=8, Depth=4; BitCycles=11, FrameCycles=121)
REQ-034 Single push 0xA5 at edge k into an idle, empty FIFO -> empty=0 after edge k; one tx_write in the cycle after edge k+1; tx_data=0xA5 held 122 cycles; busy falls after that.
REQ-035 Push 0x11, 0x22, 0x33 on consecutive cycles -> three tx_write pulses, 123 cycles apart, carrying 0x11, 0x22, 0x33 in order; level steps down to 0.
REQ-036 While WAIT is busy, push 5 bytes 0x01..0x05 -> full=1 after the fourth push; 0x05 dropped; overflow=1 (macro on) or 0 (macro off); later output is 0x01..0x04 only.
REQ-037 At full, push and pop in the same cycle -> push dropped; level becomes 3.
REQ-038 Assert rst 50 cycles into a frame with 2 bytes queued -> all outputs return to their reset values immediately; no tx_write afterwards without a new push.
REQ-039 Macro on, overflow=1: pulse clear_overflow -> overflow=0 next cycle; clear_overflow and a dropped push in the same cycle -> overflow stays 1.
